cg_rvarch_decode_stage: RTL and testbench

//  RV32I decode stage, directly downstream of fetch. Accepts {pc, instr} beats over valid/ready.

---
 rtl/cg_rvarch_instr_field_pkg.sv | 165 ++++++++++++++++
 rtl/cg_skid_buffer.sv | 82 ++++++++
 rtl/cg_rvarch_decode_stage.sv | 47 ++++
 tb/tb_cg_rvarch_decode_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cg_rvarch_instr_field_pkg.sv
// ---------------------------------------------------------------------------
// cg_rvarch_instr_field_pkg
// RV32I instruction field helpers shared by the pipeline stages.
// Provides the opcode constants, field extractors, immediate builders,
// opcode class predicates and the decode() function that turns a raw
// {pc, instr} beat into the dec_t bundle consumed by issue/execute.
// ---------------------------------------------------------------------------
package cg_rvarch_instr_field_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef logic [INSTR_WIDTH-1:0] instr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm;
    logic            rd_we;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            illegal;
  } dec_t;

  function automatic logic [6:0] get_opcode(input instr_t instr);
    return instr[6:0];
  endfunction

  function automatic logic [31:0] i_imm(input instr_t instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] s_imm(input instr_t instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] b_imm(input instr_t instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] u_imm(input instr_t instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] j_imm(input instr_t instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // Opcodes without an immediate operand (OP, MISC_MEM, SYSTEM, unknown) give 0.
  function automatic logic [31:0] get_imm(input instr_t instr);
    logic [31:0] imm;
    imm = '0;
    case (get_opcode(instr))
      OPC_LUI, OPC_AUIPC:            imm = u_imm(instr);
      OPC_JAL:                       imm = j_imm(instr);
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: imm = i_imm(instr);
      OPC_BRANCH:                    imm = b_imm(instr);
      OPC_STORE:                     imm = s_imm(instr);
      default:                       imm = '0;
    endcase
    return imm;
  endfunction

  // The opcode constants all end in 2'b11, so a match also covers instr[1:0].
  function automatic logic is_legal_opcode(input instr_t instr);
    logic legal;
    case (get_opcode(instr))
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
      default:                                                  legal = 1'b0;
    endcase
    return legal && (instr[1:0] == 2'b11);
  endfunction

  function automatic logic is_load_opcode(input instr_t instr);
    return get_opcode(instr) == OPC_LOAD;
  endfunction

  function automatic logic is_store_opcode(input instr_t instr);
    return get_opcode(instr) == OPC_STORE;
  endfunction

  function automatic logic is_branch_opcode(input instr_t instr);
    return get_opcode(instr) == OPC_BRANCH;
  endfunction

  function automatic logic is_jump_opcode(input instr_t instr);
    return (get_opcode(instr) == OPC_JAL) || (get_opcode(instr) == OPC_JALR);
  endfunction

  // SYSTEM is included because the CSR instructions write rd.
  function automatic logic is_rd_opcode(input instr_t instr);
    logic wr;
    case (get_opcode(instr))
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
      OPC_OP_IMM, OPC_OP, OPC_SYSTEM: wr = 1'b1;
      default:                        wr = 1'b0;
    endcase
    return wr;
  endfunction

  function automatic logic uses_rs1(input instr_t instr);
    logic u;
    case (get_opcode(instr))
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: u = 1'b0;
      default:                                              u = 1'b1;
    endcase
    return u && is_legal_opcode(instr);
  endfunction

  function automatic logic uses_rs2(input instr_t instr);
    return (get_opcode(instr) == OPC_BRANCH) || (get_opcode(instr) == OPC_STORE) ||
           (get_opcode(instr) == OPC_OP);
  endfunction

  // Raw fields are always extracted; everything with meaning is gated by
  // legality so illegal beats carry no class flags, no rd write and imm=0.
  function automatic dec_t decode(input logic [XLEN-1:0] pc, input instr_t instr);
    dec_t d;
    logic legal;
    legal    = is_legal_opcode(instr);
    d        = '0;
    d.pc     = pc;
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct3 = instr[14:12];
    d.funct7 = instr[31:25];
    d.illegal = !legal;
    if (legal) begin
      d.imm       = get_imm(instr);
      d.rd_we     = is_rd_opcode(instr) && (instr[11:7] != 5'd0);
      d.uses_rs1  = uses_rs1(instr);
      d.uses_rs2  = uses_rs2(instr);
      d.is_load   = is_load_opcode(instr);
      d.is_store  = is_store_opcode(instr);
      d.is_branch = is_branch_opcode(instr);
      d.is_jump   = is_jump_opcode(instr);
    end
    return d;
  endfunction

endpackage

// File: rtl/cg_skid_buffer.sv
// ---------------------------------------------------------------------------
// cg_skid_buffer
// Generic 2-entry valid/ready skid buffer with flush. MAIN drives the output,
// SKID absorbs the one beat that arrives while MAIN is stalled. o_ready is a
// flop so no combinational path runs from i_ready back to o_ready.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_flush            drop both entries and any beat accepted this cycle
//   i_valid/o_ready    upstream handshake, i_data payload
//   o_valid/i_ready    downstream handshake, o_data payload (MAIN entry)
// ---------------------------------------------------------------------------
module cg_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             ready_q;
  logic             in_fire;
  logic             main_free;

  // ready_q always equals !skid_valid_q, so in_fire never coincides with a full SKID.
  assign in_fire   = i_valid && ready_q;
  assign main_free = !main_valid_q || i_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (i_flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Older beat in SKID goes first to keep arrival order.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) main_data_d = i_data;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = main_valid_q;
  assign o_data  = main_data_q;

endmodule

// File: rtl/cg_rvarch_decode_stage.sv
// ---------------------------------------------------------------------------
// cg_rvarch_decode_stage
// RV32I decode stage behind fetch. Each {pc, instr} beat is decoded
// combinationally and only the decoded bundle is stored in a 2-entry skid
// buffer, giving one-cycle latency and full throughput.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_flush            redirect: drop held and incoming beats
//   i_valid/o_ready    fetch handshake, i_pc / i_instr payload
//   o_valid/i_ready    issue handshake, o_dec decoded bundle
// ---------------------------------------------------------------------------
module cg_rvarch_decode_stage
  import cg_rvarch_instr_field_pkg::*;
#(
  parameter int XLEN = cg_rvarch_instr_field_pkg::XLEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [XLEN-1:0]        i_pc,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic                   o_valid,
  input  logic                   i_ready,
  output dec_t                   o_dec
);

  dec_t dec_in;

  assign dec_in = decode(i_pc, i_instr);

  cg_skid_buffer #(
    .WIDTH($bits(dec_t))
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (dec_in),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_dec)
  );

endmodule

// File: tb/tb_cg_rvarch_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_cg_rvarch_decode_stage
// Directed bench for the decode stage with a scoreboard of expected bundles.
// ---------------------------------------------------------------------------
module tb_cg_rvarch_decode_stage;
  import cg_rvarch_instr_field_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        vin = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        o_ready;
  logic        o_valid;
  dec_t        o_dec;

  dec_t exp_q[$];
  dec_t cur_exp;
  logic acc;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   n_cyc = 0;
  int   c0, o0;

  always #5 clk = ~clk;

  cg_rvarch_decode_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_valid (vin),
    .o_ready (o_ready),
    .i_pc    (pc),
    .i_instr (instr),
    .o_valid (o_valid),
    .i_ready (rdy_in),
    .o_dec   (o_dec)
  );

  // flags = {rd_we, uses_rs1, uses_rs2, is_load, is_store, is_branch, is_jump, illegal}
  function automatic dec_t mk(input logic [31:0] p, input logic [31:0] ins,
                              input logic [31:0] imm, input logic [7:0] f);
    dec_t d;
    d.pc     = p;
    d.opcode = ins[6:0];
    d.rd     = ins[11:7];
    d.rs1    = ins[19:15];
    d.rs2    = ins[24:20];
    d.funct3 = ins[14:12];
    d.funct7 = ins[31:25];
    d.imm    = imm;
    {d.rd_we, d.uses_rs1, d.uses_rs2, d.is_load, d.is_store, d.is_branch, d.is_jump, d.illegal} = f;
    return d;
  endfunction

  task automatic chk_dec(input string tag, input dec_t obs, input dec_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, update scoreboard, step past the rising edge.
  task automatic cycle();
    dec_t e;
    @(negedge clk);
    acc = vin && o_ready;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (o_valid && rdy_in) begin
        if (exp_q.size() == 0) begin
          chk_bit("unexpected_output", o_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          chk_dec("out_bundle", o_dec, e);
          $display("out pc=%h instr_op=%h imm=%h", o_dec.pc, o_dec.opcode, o_dec.imm);
        end
      end
      if (acc) exp_q.push_back(cur_exp);
    end
    n_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] p, input logic [31:0] ins,
                         input logic [31:0] imm, input logic [7:0] f);
    pc      = p;
    instr   = ins;
    vin     = 1'b1;
    cur_exp = mk(p, ins, imm, f);
  endtask

  task automatic wait_accept();
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) chk_bit("accept_timeout", acc, 1'b1);
    vin = 1'b0;
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] ins,
                      input logic [31:0] imm, input logic [7:0] f);
    present(p, ins, imm, f);
    wait_accept();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle();
    chk_int("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_bit("rst_o_valid", o_valid, 1'b0);
    chk_bit("rst_o_ready", o_ready, 1'b1);
    chk_dec("rst_o_dec", o_dec, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: addi x1,x0,5
    rdy_in = 1'b1;
    send(32'h100, 32'h00500093, 32'd5, 8'b1100_0000);
    chk_bit("latency_addi", o_valid, 1'b1);
    chk_dec("addi_presented", o_dec, exp_q[0]);
    // 2: sw x2,-4(x1) then lui x5,0xABCDE, back to back
    send(32'h104, 32'hFE20AE23, 32'hFFFF_FFFC, 8'b0110_1000);
    send(32'h108, 32'hABCDE2B7, 32'hABCD_E000, 8'b1000_0000);
    drain();

    // 3: four beats with the consumer stalled
    rdy_in = 1'b0;
    send(32'h200, 32'h00208463, 32'h0000_0008, 8'b0110_0100);  // beq x1,x2,8
    chk_bit("main_held_ready", o_ready, 1'b1);
    send(32'h204, 32'h010000EF, 32'h0000_0010, 8'b1000_0010);  // jal x1,16
    chk_bit("skid_full_ready", o_ready, 1'b0);
    present(32'h208, 32'hFF812383, 32'hFFFF_FFF8, 8'b1101_0000); // lw x7,-8(x2)
    cycle();
    chk_bit("beat3_not_taken", acc, 1'b0);
    cycle();
    chk_bit("stall_o_valid", o_valid, 1'b1);
    chk_dec("stall_hold_stable", o_dec, exp_q[0]);
    rdy_in = 1'b1;
    c0 = n_cyc;
    o0 = n_out;
    wait_accept();
    send(32'h20C, 32'h00100193, 32'h0000_0001, 8'b1100_0000); // addi x3,x0,1
    cycle();
    chk_int("throughput_outs", n_out - o0, 4);
    chk_int("throughput_cycles", n_cyc - c0, 4);
    drain();

    // 4: illegal encodings and the canonical nop
    send(32'h300, 32'h0000_0000, 32'h0, 8'b0000_0001);
    send(32'h304, 32'hFFFF_FFFF, 32'h0, 8'b0000_0001);
    send(32'h308, 32'h0000_0013, 32'h0, 8'b0100_0000);
    drain();

    // 5: flush with both entries full and a beat on the bus
    rdy_in = 1'b0;
    send(32'h400, 32'h00200213, 32'd2, 8'b1100_0000);
    send(32'h404, 32'h00300293, 32'd3, 8'b1100_0000);
    chk_bit("flush_pre_ready", o_ready, 1'b0);
    present(32'h408, 32'h00400313, 32'd4, 8'b1100_0000);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    vin = 1'b0;
    chk_bit("flush_o_valid", o_valid, 1'b0);
    chk_bit("flush_o_ready", o_ready, 1'b1);
    // Beat accepted in the flush cycle is discarded
    present(32'h40C, 32'h00500093, 32'd5, 8'b1100_0000);
    flush = 1'b1;
    cycle();
    chk_bit("flush_accept_seen", acc, 1'b1);
    flush = 1'b0;
    vin = 1'b0;
    chk_bit("flush_accept_o_valid", o_valid, 1'b0);
    rdy_in = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    send(32'h410, 32'h00100193, 32'd1, 8'b1100_0000);
    drain();

    // 6: async reset with MAIN and SKID full
    rdy_in = 1'b0;
    send(32'h500, 32'h00200213, 32'd2, 8'b1100_0000);
    send(32'h504, 32'h00300293, 32'd3, 8'b1100_0000);
    chk_bit("prerst_o_valid", o_valid, 1'b1);
    chk_bit("prerst_o_ready", o_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_bit("async_rst_o_valid", o_valid, 1'b0);
    chk_bit("async_rst_o_ready", o_ready, 1'b1);
    chk_dec("async_rst_o_dec", o_dec, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_in = 1'b1;
    send(32'h600, 32'h00400313, 32'd4, 8'b1100_0000);
    chk_bit("post_rst_latency", o_valid, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
